// File: rtl/pc_stack_sequencer.sv
// Program counter and call-stack counter sequencer: turns decoder control into
// PC/SC updates, call/return stack-memory strobes, and an error halt.
module pc_stack_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] STK_TOP  = 16'h00FF,
  parameter int              STK_MAX  = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            step,
  input  logic            pcl,
  input  logic [1:0]      pcds,
  input  logic            br,
  input  logic            bit_op,
  input  logic [1:0]      scn,
  input  logic [PC_W-1:0] literal,
  input  logic [PC_W-1:0] call_ad,
  input  logic [PC_W-1:0] reg_data,
  input  logic [7:0]      er_cde,
  input  logic [PC_W-1:0] stk_rdata,
  input  logic            clear_err,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      sc,
  output logic            ready,
  output logic [PC_W-1:0] stk_addr,
  output logic            stk_we,
  output logic [PC_W-1:0] stk_wdata,
  output logic            stk_re,
  output logic            halted,
  output logic [7:0]      err_code
);

  typedef enum logic [1:0] {RUN, RET_WAIT, HALT} state_t;

  localparam logic [1:0] PCDS_LIT = 2'b00;
  localparam logic [1:0] PCDS_REG = 2'b01;
  localparam logic [1:0] PCDS_RET = 2'b10;
  localparam logic [1:0] PCDS_CAL = 2'b11;

  localparam logic [1:0] SCN_PUSH = 2'b01;
  localparam logic [1:0] SCN_POP  = 2'b10;
  localparam logic [1:0] SCN_ILL  = 2'b11;

  state_t          state;
  logic [7:0]      err_nxt;
  logic [2:0]      sc_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] sc_ext;
  logic            is_call;
  logic            is_ret;

  assign pc_inc  = pc + PC_W'(1);
  assign sc_ext  = {{(PC_W-3){1'b0}}, sc};
  assign is_call = pcl && (pcds == PCDS_CAL);
  assign is_ret  = pcl && (pcds == PCDS_RET);

  // Decoder-reported errors outrank the sequencer's own stack guards.
  always_comb begin
    err_nxt = 8'h00;
    if (er_cde != 8'h00)                            err_nxt = er_cde;
    else if (scn == SCN_ILL)                        err_nxt = 8'hFF;
    else if (scn == SCN_PUSH && sc == 3'(STK_MAX))  err_nxt = 8'hFE;
    else if (scn == SCN_POP && sc == 3'd0)          err_nxt = 8'hFD;
  end

  always_comb begin
    sc_nxt = sc;
    case (scn)
      SCN_PUSH: sc_nxt = sc + 3'd1;
      SCN_POP:  sc_nxt = sc - 3'd1;
      default:  sc_nxt = sc;
    endcase
  end

  always_comb begin
    pc_nxt = pc_inc;
    if (pcl) begin
      case (pcds)
        PCDS_LIT: pc_nxt = br ? (pc + literal) : literal;
        PCDS_REG: pc_nxt = bit_op ? (pc + PC_W'(2)) : reg_data;
        PCDS_RET: pc_nxt = pc;
        PCDS_CAL: pc_nxt = pc + call_ad;
        default:  pc_nxt = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= RESET_PC;
      sc        <= 3'd0;
      ready     <= 1'b1;
      halted    <= 1'b0;
      err_code  <= 8'h00;
      stk_we    <= 1'b0;
      stk_re    <= 1'b0;
      stk_addr  <= '0;
      stk_wdata <= '0;
    end else begin
      stk_we <= 1'b0;
      stk_re <= 1'b0;
      case (state)
        RUN: begin
          if (step) begin
            if (err_nxt != 8'h00) begin
              err_code <= err_nxt;
              halted   <= 1'b1;
              ready    <= 1'b0;
              state    <= HALT;
            end else begin
              pc <= pc_nxt;
              sc <= sc_nxt;
              // Stack address uses the count before this edge's SC step.
              if (is_call) begin
                stk_we    <= 1'b1;
                stk_addr  <= STK_TOP - sc_ext;
                stk_wdata <= pc_inc;
              end
              if (is_ret) begin
                stk_re   <= 1'b1;
                stk_addr <= STK_TOP - sc_ext + PC_W'(1);
                ready    <= 1'b0;
                state    <= RET_WAIT;
              end
            end
          end
        end
        RET_WAIT: begin
          pc    <= stk_rdata;
          ready <= 1'b1;
          state <= RUN;
        end
        HALT: begin
          if (clear_err) begin
            err_code <= 8'h00;
            halted   <= 1'b0;
            ready    <= 1'b1;
            state    <= RUN;
          end
        end
        default: begin
          ready  <= 1'b1;
          halted <= 1'b0;
          state  <= RUN;
        end
      endcase
    end
  end

endmodule
